// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per start handshake against a word-wide, big-endian,
// byte-addressed data memory; sub-word stores use read-modify-write, bad requests fault.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_RW,
  output logic [31:0] mem_DAddr,
  output logic [31:0] mem_DataIn,
  input  logic [31:0] mem_result
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_t;

  state_t      state, state_n;
  op_t         op_q;
  logic [31:0] addr_q, wdata_q, rbuf;
  logic        fault_q;

  logic        req_fault;
  logic        is_load;
  logic [1:0]  k;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  // The aligned word's last byte must lie inside memory; alignment depends on access size.
  always_comb begin
    req_fault = (({addr[31:2], 2'b00} + 32'd3) >= 32'(MEM_BYTES));
    case (op_t'(op))
      OP_LW, OP_SW:         if (addr[1:0] != 2'b00) req_fault = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (addr[0]) req_fault = 1'b1;
      default: ;
    endcase
  end

  assign is_load = (op_q < OP_SW);
  assign k       = addr_q[1:0];

  always_comb begin
    case (k)
      2'd0:    ld_byte = mem_result[31:24];
      2'd1:    ld_byte = mem_result[23:16];
      2'd2:    ld_byte = mem_result[15:8];
      default: ld_byte = mem_result[7:0];
    endcase
    ld_half = k[1] ? mem_result[15:0] : mem_result[31:16];
    case (op_q)
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'h0000, ld_half};
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'h000000, ld_byte};
      default: ld_val = mem_result;
    endcase
  end

  always_comb begin
    merged = rbuf;
    case (op_q)
      OP_SW: merged = wdata_q;
      OP_SH: merged = k[1] ? {rbuf[31:16], wdata_q[15:0]} : {wdata_q[15:0], rbuf[15:0]};
      OP_SB: begin
        case (k)
          2'd0:    merged[31:24] = wdata_q[7:0];
          2'd1:    merged[23:16] = wdata_q[7:0];
          2'd2:    merged[15:8]  = wdata_q[7:0];
          default: merged[7:0]   = wdata_q[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      rdata   <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          op_q    <= op_t'(op);
          addr_q  <= addr;
          wdata_q <= wdata;
          fault_q <= req_fault;
          rdata   <= '0;
        end
        READ: begin
          rbuf <= mem_result;
          if (is_load) rdata <= ld_val;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    fault      = 1'b0;
    mem_RW     = 1'b0;
    mem_DAddr  = {addr_q[31:2], 2'b00};
    mem_DataIn = '0;
    case (state)
      IDLE: begin
        mem_DAddr = '0;
        if (start) begin
          if (req_fault)               state_n = DONE;
          else if (op_t'(op) == OP_SW) state_n = WRITE;
          else                         state_n = READ;
        end
      end
      READ:  state_n = is_load ? DONE : WRITE;
      WRITE: begin
        mem_RW     = 1'b1;
        mem_DataIn = merged;
        state_n    = DONE;
      end
      default: begin
        done    = 1'b1;
        fault   = fault_q;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model on the DUT side, byte-level reference
// model for expected load data, memory contents, latency and fault.
module tb_load_store_unit;
  localparam int unsigned MB = 124;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, fault, mem_RW;
  logic [31:0] rdata, mem_DAddr, mem_DataIn, mem_result;

  logic [7:0]  tb_mem  [0:127];
  logic [7:0]  ref_mem [0:127];
  int unsigned wr_count = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata), .mem_RW(mem_RW),
    .mem_DAddr(mem_DAddr), .mem_DataIn(mem_DataIn), .mem_result(mem_result)
  );

  always #5 CLK = ~CLK;

  // Data memory: commits on the negedge inside a write cycle, reads combinationally.
  always @(negedge CLK) begin
    if (mem_RW) begin
      wr_count = wr_count + 1;
      if (mem_DAddr <= 32'd124) begin
        tb_mem[mem_DAddr[6:0]]         = mem_DataIn[31:24];
        tb_mem[mem_DAddr[6:0] + 7'd1]  = mem_DataIn[23:16];
        tb_mem[mem_DAddr[6:0] + 7'd2]  = mem_DataIn[15:8];
        tb_mem[mem_DAddr[6:0] + 7'd3]  = mem_DataIn[7:0];
      end
    end
  end

  always_comb begin
    mem_result = '0;
    if (mem_DAddr <= 32'd124)
      mem_result = {tb_mem[mem_DAddr[6:0]], tb_mem[mem_DAddr[6:0] + 7'd1],
                    tb_mem[mem_DAddr[6:0] + 7'd2], tb_mem[mem_DAddr[6:0] + 7'd3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_fault(input logic [2:0] o, input logic [31:0] a);
    if ((a - (a % 4)) + 3 >= MB) return 1'b1;
    if ((o == 3'd0 || o == 3'd5) && (a % 4) != 0) return 1'b1;
    if ((o == 3'd1 || o == 3'd2 || o == 3'd6) && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  function automatic logic [31:0] tb_word(input int i);
    return {tb_mem[i], tb_mem[i+1], tb_mem[i+2], tb_mem[i+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
    int i, v;
    i = int'(a % 128);
    case (o)
      3'd0: return ref_word(i);
      3'd1, 3'd2: begin
        v = int'(ref_mem[i]) * 256 + int'(ref_mem[i+1]);
        if (o == 3'd1 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      default: begin
        v = int'(ref_mem[i]);
        if (o == 3'd3 && v >= 128) v = v - 256;
        return 32'(v);
      end
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a % 128);
    if (o == 3'd5) begin
      ref_mem[i] = d[31:24]; ref_mem[i+1] = d[23:16];
      ref_mem[i+2] = d[15:8]; ref_mem[i+3] = d[7:0];
    end else if (o == 3'd6) begin
      ref_mem[i] = d[15:8]; ref_mem[i+1] = d[7:0];
    end else begin
      ref_mem[i] = d[7:0];
    end
  endtask

  // Entered and left one time unit after a posedge with the FSM idle.
  task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        input string tag, output logic [31:0] rd_obs);
    bit f, st;
    int lat, exp_lat;
    int unsigned w0;
    logic [31:0] exp_rd;
    f       = ref_fault(o, a);
    st      = (o >= 3'd5);
    exp_lat = f ? 1 : (o == 3'd6 || o == 3'd7) ? 3 : 2;
    exp_rd  = (!f && !st) ? ref_load(o, a) : 32'h0;
    w0      = wr_count;
    start = 1'b1; op = o; addr = a; wdata = d;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 1;
    if (!f) check({tag, " daddr"}, mem_DAddr, a & ~32'd3);
    while (!done && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " fault"}, 32'(fault), 32'(f));
    check({tag, " rdata"}, rdata, exp_rd);
    rd_obs = rdata;
    if (!f && st) ref_store(o, a, d);
    @(posedge CLK); #1;
    check({tag, " writes"}, 32'(wr_count - w0), (!f && st) ? 32'd1 : 32'd0);
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, " datain idle"}, mem_DataIn, 32'd0);
    if (!f) check({tag, " word"}, tb_word(int'(a % 128) & ~3), ref_word(int'(a % 128) & ~3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, exp_lw;
    int unsigned w0;
    int lat;
    logic [2:0] ro;
    logic [31:0] ra;
    bit mem_ok;

    for (int i = 0; i < 128; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end

    repeat (2) @(posedge CLK);
    #1;
    check("reset flags", {28'd0, busy, done, fault, mem_RW}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset daddr", mem_DAddr, 32'd0);
    check("reset datain", mem_DataIn, 32'd0);
    Reset = 1'b1;
    @(posedge CLK); #1;

    do_req(3'd5, 32'd8, 32'hDEADBEEF, "sw8", r);
    do_req(3'd0, 32'd8, 32'h0, "lw8", r);
    check("lw8 const", r, 32'hDEADBEEF);
    do_req(3'd7, 32'd9, 32'h00000055, "sb9", r);
    check("sb9 word", tb_word(8), 32'hDE55BEEF);
    do_req(3'd3, 32'd9, 32'h0, "lb9", r);
    check("lb9 const", r, 32'h00000055);
    do_req(3'd4, 32'd10, 32'h0, "lbu10", r);
    check("lbu10 const", r, 32'h000000BE);
    do_req(3'd6, 32'd10, 32'h00008001, "sh10", r);
    check("sh10 word", tb_word(8), 32'hDE558001);
    do_req(3'd1, 32'd10, 32'h0, "lh10", r);
    check("lh10 const", r, 32'hFFFF8001);
    do_req(3'd2, 32'd10, 32'h0, "lhu10", r);
    check("lhu10 const", r, 32'h00008001);

    do_req(3'd0, 32'd6, 32'h0, "flt lw6", r);
    do_req(3'd6, 32'd3, 32'h1234, "flt sh3", r);
    do_req(3'd5, 32'd124, 32'h11223344, "flt sw124", r);
    do_req(3'd5, 32'd120, 32'hA5A55A5A, "sw120 edge", r);
    do_req(3'd3, 32'd123, 32'h0, "lb123 edge", r);
    do_req(3'd4, 32'd124, 32'h0, "flt lbu124", r);
    do_req(3'd7, 32'hFFFF_FFF0, 32'h77, "flt sb high", r);

    // Abort a store while it is in WRITE, before the committing negedge.
    w0 = wr_count;
    start = 1'b1; op = 3'd5; addr = 32'd16; wdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    start = 1'b0;
    check("abort pre rw", 32'(mem_RW), 32'd1);
    Reset = 1'b0;
    #1;
    check("abort rw drop", 32'(mem_RW), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    @(negedge CLK); #2;
    Reset = 1'b1;
    @(posedge CLK); #1;
    check("abort no done", {30'd0, busy, done}, 32'd0);
    check("abort writes", 32'(wr_count - w0), 32'd0);
    check("abort word", tb_word(16), ref_word(16));

    // Start held high through a busy SB: second request waits until after done.
    w0 = wr_count;
    exp_lw = ref_word(44);
    start = 1'b1; op = 3'd7; addr = 32'd41; wdata = 32'h000000A5;
    @(posedge CLK); #1;
    op = 3'd0; addr = 32'd44;
    lat = 1;
    while (!done && lat < 8) begin
      check("held busy", 32'(busy), 32'd1);
      @(posedge CLK); #1;
      lat++;
    end
    check("held sb latency", 32'(lat), 32'd3);
    ref_store(3'd7, 32'd41, 32'h000000A5);
    @(posedge CLK); #1;
    check("held idle gap", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    start = 1'b0;
    check("held accept", 32'(busy), 32'd1);
    @(posedge CLK); #1;
    check("held lw done", 32'(done), 32'd1);
    check("held lw rdata", rdata, exp_lw);
    @(posedge CLK); #1;
    check("held writes", 32'(wr_count - w0), 32'd1);
    check("held word", tb_word(40), ref_word(40));

    for (int n = 0; n < 300; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      do_req(ro, ra, $urandom, "rand", r);
    end

    mem_ok = 1'b1;
    for (int i = 0; i < 124; i++) if (tb_mem[i] !== ref_mem[i]) mem_ok = 1'b0;
    check("final memory", 32'(mem_ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
